// File: rtl/wca_elastic_passthrough_if.sv
// Ready/valid handshake bundle for the elastic passthrough: upstream write
// channel and downstream read channel, seen from the buffer (slave) or the driver (master).
interface wca_elastic_passthrough_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/wca_elastic_passthrough.sv
// DEPTH-entry first-word-fall-through elastic buffer with run/stall gating,
// synchronous flush and an occupancy report; words pass unchanged and in order.
module wca_elastic_passthrough #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           flush,
  wca_elastic_passthrough_if.slave       bus,
  output logic [AW:0]                    level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             wr, rd;

  // Handshakes depend only on registered occupancy plus enable/flush, never on
  // out_ready; reset_n gates in_ready so it reads 0 while reset is held.
  assign bus.in_ready  = reset_n & enable & ~flush & (level_q != LVL_FULL);
  assign bus.out_valid = enable & ~flush & (level_q != '0);
  assign bus.out_data  = out_data_q;
  assign level         = level_q;

  assign wr = bus.in_valid  & bus.in_ready;
  assign rd = bus.out_valid & bus.out_ready;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_data_d = out_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr, rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // Head word for next cycle: the incoming word when it lands in the head slot.
      if (wr || rd) begin
        if (wr && (wr_ptr_q == rd_ptr_d)) out_data_d = bus.in_data;
        else                              out_data_d = mem[rd_ptr_d];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
    end
  end

  // NOTE: storage has no reset; occupancy tracking guarantees stale entries are never presented.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr_q] <= bus.in_data;
  end

endmodule

// File: tb/tb_wca_elastic_passthrough.sv
// Directed bench for wca_elastic_passthrough: handshake, ordering, full/empty
// boundaries, flush, stall and async reset, plus a queue-modelled random stream.
module tb_wca_elastic_passthrough;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       flush;
  logic [2:0] level;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [15:0] sb [$];

  wca_elastic_passthrough_if #(.WIDTH(16)) bus ();

  wca_elastic_passthrough #(.WIDTH(16), .DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .flush   (flush),
    .bus     (bus),
    .level   (level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b1;
    flush         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    // Reset state
    check("rst_level",    32'(level), 0);
    check("rst_ovalid",   32'(bus.out_valid), 0);
    check("rst_iready",   32'(bus.in_ready), 0);
    check("rst_odata",    32'(bus.out_data), 0);
    reset_n = 1'b1;
    #1;
    check("post_rst_iready", 32'(bus.in_ready), 1);

    // T1: single word, one-cycle latency
    bus.in_data   = 16'hA5A5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t1_ovalid_pre", 32'(bus.out_valid), 0);
    cyc();
    bus.in_valid = 1'b0;
    check("t1_ovalid", 32'(bus.out_valid), 1);
    check("t1_odata",  32'(bus.out_data), 32'hA5A5);
    check("t1_level1", 32'(level), 1);
    cyc();
    check("t1_level0", 32'(level), 0);
    check("t1_ovalid0", 32'(bus.out_valid), 0);

    // T2: fill past DEPTH with back-pressure, then drain
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data  = 16'(i);
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("t2_iready_%0d", i), 32'(bus.in_ready), (i <= 4) ? 1 : 0);
      cyc();
    end
    check("t2_level_full", 32'(level), 4);
    check("t2_iready_full", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1;
    check("t2_iready_full_rd", 32'(bus.in_ready), 0);
    check("t2_out1", 32'(bus.out_data), 1);
    cyc();
    check("t2_out2", 32'(bus.out_data), 2);
    check("t2_iready_3", 32'(bus.in_ready), 1);
    check("t2_level3", 32'(level), 3);
    cyc();
    bus.in_valid = 1'b0;
    check("t2_out3", 32'(bus.out_data), 3);
    check("t2_level3b", 32'(level), 3);
    cyc();
    check("t2_out4", 32'(bus.out_data), 4);
    cyc();
    check("t2_out5", 32'(bus.out_data), 5);
    check("t2_ovalid5", 32'(bus.out_valid), 1);
    cyc();
    check("t2_empty", 32'(level), 0);
    check("t2_ovalid0", 32'(bus.out_valid), 0);

    // T4: full with simultaneous read request; write waits a cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'h0010 + 16'(i));
    bus.in_data   = 16'h0014;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t4_level4", 32'(level), 4);
    check("t4_iready0", 32'(bus.in_ready), 0);
    cyc();
    bus.out_ready = 1'b0;
    check("t4_level3", 32'(level), 3);
    check("t4_iready1", 32'(bus.in_ready), 1);
    check("t4_head", 32'(bus.out_data), 32'h11);
    cyc();
    bus.in_valid = 1'b0;
    check("t4_level4b", 32'(level), 4);
    check("t4_head_stable", 32'(bus.out_data), 32'h11);

    // T5: flush at level 3 beats concurrent write and read
    bus.out_ready = 1'b1;
    cyc();
    check("t5_level3", 32'(level), 3);
    flush        = 1'b1;
    bus.in_data  = 16'h0BAD;
    bus.in_valid = 1'b1;
    #1;
    check("t5_iready_fl", 32'(bus.in_ready), 0);
    check("t5_ovalid_fl", 32'(bus.out_valid), 0);
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("t5_level0", 32'(level), 0);
    check("t5_ovalid0", 32'(bus.out_valid), 0);
    cyc();
    check("t5_still_empty", 32'(bus.out_valid), 0);

    // T6: stall with two words held, then drain
    bus.out_ready = 1'b0;
    write_word(16'h0021);
    write_word(16'h0022);
    enable        = 1'b0;
    bus.in_data   = 16'h0033;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t6_stall_ovalid", 32'(bus.out_valid), 0);
      check("t6_stall_iready", 32'(bus.in_ready), 0);
      check("t6_stall_level",  32'(level), 2);
      check("t6_stall_odata",  32'(bus.out_data), 32'h21);
      cyc();
    end
    enable       = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("t6_drain1", 32'(bus.out_data), 32'h21);
    check("t6_drain1_v", 32'(bus.out_valid), 1);
    cyc();
    check("t6_drain2", 32'(bus.out_data), 32'h22);
    cyc();
    check("t6_drained", 32'(level), 0);

    // Async reset mid-stream
    bus.out_ready = 1'b0;
    write_word(16'h0041);
    write_word(16'h0042);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_level",  32'(level), 0);
    check("arst_ovalid", 32'(bus.out_valid), 0);
    check("arst_iready", 32'(bus.in_ready), 0);
    check("arst_odata",  32'(bus.out_data), 0);
    cyc();
    #2;
    reset_n = 1'b1;
    cyc();

    // T3: random stream against a queue model
    for (int c = 0; c < 1000; c++) begin
      logic exp_ir, exp_ov;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ir = (sb.size() != 4);
      exp_ov = (sb.size() != 0);
      check("t3_level",  32'(level), 32'(sb.size()));
      check("t3_iready", 32'(bus.in_ready), 32'(exp_ir));
      check("t3_ovalid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov && bus.out_ready) begin
        check("t3_data", 32'(bus.out_data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (exp_ir && bus.in_valid) sb.push_back(bus.in_data);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      #1;
      check("t3_drain_v", 32'(bus.out_valid), 1);
      check("t3_drain_d", 32'(bus.out_data), 32'(sb[0]));
      void'(sb.pop_front());
      cyc();
    end
    #1;
    check("t3_final_level", 32'(level), 0);
    check("t3_final_ovalid", 32'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
